// File: rtl/fifo_fwft_stream.sv
// First-word-fall-through stream FIFO. Valid/ready handshake on both sides, occupancy count,
// almost-full/almost-empty flags, synchronous flush and a sticky overflow flag.
module fifo_fwft_stream #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              err_clr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              overflow_q, overflow_d;
  logic              full, empty, push, pop;

  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Flush cancels any transfer offered in the same cycle.
  assign push = reset_n & ~flush & wr_valid & ~full;
  assign pop  = reset_n & ~flush & rd_ready & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = '0;
    overflow_d = (wr_valid & full) | (overflow_q & ~err_clr);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end

    // Head register: registered read at the next read pointer, bypassing a word that
    // is being written into the very slot that becomes the head.
    if (count_d == '0)
      rd_data_d = '0;
    else if (push && (wr_ptr_q == rd_ptr_d))
      rd_data_d = wr_data;
    else
      rd_data_d = mem[rd_ptr_d[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
  end

  assign wr_ready     = ~full;
  assign rd_valid     = ~empty;
  assign rd_data      = rd_data_q;
  assign count        = count_q;
  assign almost_full  = (count_q >= (ADDR_W + 1)'(AF_LEVEL));
  assign almost_empty = (count_q <= (ADDR_W + 1)'(AE_LEVEL));
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_fifo_fwft_stream.sv
// Bench for fifo_fwft_stream: directed scenarios then random traffic, checked against a
// queue-based model with a scoreboard popping on every accepted read.
module tb_fifo_fwft_stream;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AF     = 12;
  localparam int AE     = 2;

  logic              clk = 1'b0;
  logic              reset_n, flush, err_clr, wr_valid, rd_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready, rd_valid, almost_full, almost_empty, overflow;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   count;

  fifo_fwft_stream #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .err_clr(err_clr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [DATA_W-1:0] exp_q[$];
  bit                m_ovf;
  bit                clean_after_reset;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act !== req)
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    else
      pass_cnt++;
  endtask

  // Reference model + scoreboard: evaluated on the pre-edge view of inputs and outputs.
  initial begin
    forever begin
      int sz;
      @(posedge clk);
      sz = exp_q.size();
      if (!reset_n) begin
        exp_q.delete();
        m_ovf = 0;
        clean_after_reset = 1;
      end else begin
        if (wr_valid && sz == DEPTH) m_ovf = 1;
        else if (err_clr)            m_ovf = 0;
        if (flush) begin
          exp_q.delete();
        end else begin
          if (rd_valid && rd_ready) begin
            if (sz == 0) check("spurious_pop", 32'(rd_data), 32'hDEAD);
            else         check("rd_data_pop", 32'(rd_data), 32'(exp_q.pop_front()));
          end else if (rd_ready && sz > 0) begin
            check("pop_missing", 32'(rd_valid), 32'd1);
          end
          if (wr_valid && sz < DEPTH) begin
            exp_q.push_back(wr_data);
            clean_after_reset = 0;
          end
        end
      end
    end
  end

  // Status monitor: compares every output against the model after each edge.
  initial begin
    forever begin
      int sz;
      @(negedge clk);
      sz = exp_q.size();
      check("count",        32'(count),        32'(sz));
      check("wr_ready",     32'(wr_ready),     32'(sz < DEPTH));
      check("rd_valid",     32'(rd_valid),     32'(sz > 0));
      check("almost_full",  32'(almost_full),  32'(sz >= AF));
      check("almost_empty", 32'(almost_empty), 32'(sz <= AE));
      check("overflow",     32'(overflow),     32'(m_ovf));
      if (sz > 0)                 check("rd_data_head",  32'(rd_data), 32'(exp_q[0]));
      else if (clean_after_reset) check("rd_data_reset", 32'(rd_data), 32'd0);
    end
  end

  task automatic drive(input bit wv, input logic [DATA_W-1:0] wd, input bit rr,
                       input bit fl = 1'b0, input bit ec = 1'b0, input bit rn = 1'b1);
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl; err_clr = ec; reset_n = rn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 0; flush = 0; err_clr = 0; wr_valid = 0; rd_ready = 0; wr_data = '0;
    m_ovf = 0; clean_after_reset = 1;
    @(posedge clk); #1;
    drive(0, 8'h00, 0, 0, 0, 0);

    // 1: three words held, then drained
    drive(1, 8'h11, 0); drive(1, 8'h22, 0); drive(1, 8'h33, 0);
    drive(0, 8'h00, 0); drive(0, 8'h00, 0);
    repeat (3) drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);

    // 2: fill, overflow, drain, clear
    for (int i = 0; i < DEPTH; i++) drive(1, 8'(i), 0);
    drive(1, 8'hAA, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, 8'h00, 1);
    drive(0, 8'h00, 0, 0, 1);
    drive(0, 8'h00, 0);

    // 3: steady stream at count 5 for 40 cycles
    for (int i = 0; i < 5; i++) drive(1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 40; i++) drive(1, 8'(8'h45 + i), 1);
    repeat (6) drive(0, 8'h00, 1);

    // 4: push into empty with rd_ready high
    drive(1, 8'h5A, 1); drive(0, 8'h00, 1); drive(0, 8'h00, 0);

    // 5: flush at count 7 with transfers offered
    for (int i = 0; i < 7; i++) drive(1, 8'(8'h70 + i), 0);
    drive(1, 8'hFF, 1, 1);
    drive(1, 8'h3C, 0); drive(0, 8'h00, 1); drive(0, 8'h00, 0);

    // 6: reset at count 9 with overflow set
    for (int i = 0; i < DEPTH; i++) drive(1, 8'(8'h90 + i), 0);
    drive(1, 8'hEE, 0);
    repeat (7) drive(0, 8'h00, 1);
    drive(1, 8'h00, 1, 0, 0, 0);
    drive(0, 8'h00, 0); drive(0, 8'h00, 1);
    drive(1, 8'h77, 0); drive(0, 8'h00, 1); drive(0, 8'h00, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit wv, rr, fl, ec, rn;
      int bias;
      bias = (i / 250) % 3;
      wv = ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 3 : 5)));
      rr = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 8 : 5)));
      fl = ($urandom_range(0, 79) == 0);
      ec = ($urandom_range(0, 19) == 0);
      rn = ($urandom_range(0, 399) != 0);
      drive(wv, 8'($urandom), rr, fl, ec, rn);
    end
    drive(0, 8'h00, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
